// File: rtl/sm_mcu_cpu_oci_trace_monitor_pkg.sv
// Shared constants for the OCI trace capture monitor: FSM state encodings and
// overflow-mode selectors.
package sm_mcu_cpu_oci_trace_monitor_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } trace_state_e;

    localparam int OVF_OVERWRITE = 0;
    localparam int OVF_STOP      = 1;

endpackage

// File: rtl/sm_mcu_cpu_oci_trace_monitor_if.sv
// Trace capture stream (producer -> monitor) plus first-word-fall-through read
// port (monitor -> consumer).
interface sm_mcu_cpu_oci_trace_monitor_if #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4
) ();
    logic                    dct_valid;
    logic [DATA_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]        dct_count;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [CNT_W+DATA_W-1:0] rd_data;

    modport master (
        output dct_valid, dct_buffer, dct_count, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  dct_valid, dct_buffer, dct_count, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/sm_mcu_oci_trace_ram.sv
// Simple dual-port trace store: synchronous write, asynchronous read, no reset
// on the array.
module sm_mcu_oci_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sm_mcu_cpu_oci_trace_monitor.sv
// Capture monitor for the OCI debug-capture-trace stream: circular buffer with
// FWFT read port, overflow/drop tracking and end-of-test drain sequencing.
module sm_mcu_cpu_oci_trace_monitor
    import sm_mcu_cpu_oci_trace_monitor_pkg::*;
#(
    parameter int DATA_W       = 30,
    parameter int CNT_W        = 4,
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FULL = 0,
    parameter int DROP_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sm_mcu_cpu_oci_trace_monitor_if.slave trace,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WORD_W = CNT_W + DATA_W;
    localparam bit STOP_MODE = (STOP_ON_FULL == OVF_STOP);

    trace_state_e      state_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    logic              overflow_reg;
    logic [DROP_W-1:0] drop_reg;
    logic              done_reg;

    logic              wr;
    logic              pop;
    logic              full;
    logic              lost;
    logic              mem_we;
    logic              rd_adv;
    logic [WORD_W-1:0] ram_rdata;

    assign full = (level_reg == LVL_W'(DEPTH));
    assign wr   = trace.dct_valid && (trace.dct_count != '0) && (state_reg == ST_CAPTURE);
    assign pop  = trace.rd_valid && trace.rd_ready;

    // A write into a full buffer with no concurrent pop loses a word: either the
    // new one (stop mode) or the oldest one, which the read pointer skips past.
    assign lost   = wr && full && !pop;
    assign mem_we = wr && !(lost && STOP_MODE);
    assign rd_adv = pop || (lost && !STOP_MODE);

    always_comb begin
        level_next = level_reg;
        if (mem_we && !pop && !full) begin
            level_next = level_reg + LVL_W'(1);
        end else if (pop && !mem_we) begin
            level_next = level_reg - LVL_W'(1);
        end
    end

    sm_mcu_oci_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg),
        .wdata ({trace.dct_count, trace.dct_buffer}),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_reg     <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_next;
            if (lost) begin
                overflow_reg <= 1'b1;
                if (drop_reg != '1) begin
                    drop_reg <= drop_reg + DROP_W'(1);
                end
            end
        end
    end

    // DONE is judged on the post-pop level so the final pop and the transition
    // land in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_CAPTURE;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_CAPTURE: begin
                    if (test_ending || test_has_ended) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (test_has_ended && (level_next == '0)) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_CAPTURE;
                end
            endcase
        end
    end

    assign trace.rd_valid = (level_reg != '0);
    assign trace.rd_data  = trace.rd_valid ? ram_rdata : '0;
    assign level          = level_reg;
    assign overflow       = overflow_reg;
    assign drop_count     = drop_reg;
    assign state          = state_reg;
    assign done           = done_reg;

endmodule
